fetch_stage: RTL
================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, the first instruction address after reset; bits [1:0] SHALL be 0.
REQ-002 SHALL have port clk, input, 1, the single clock; every register updates on the rising edge.
REQ-003 SHALL have port rst_n, input, 1, reset; asynchronous, active-low.
REQ-004 SHALL have port stall, input, 1, hazard hold: PC and IF/ID hold their values.
REQ-005 SHALL have port redirect_valid, input, 1, branch/jump taken, resolved in ID.
REQ-006 SHALL have port redirect_pc, input, 32, branch/jump target; bits [1:0] are ignored and treated as 0.
REQ-007 SHALL have port halt, input, 1, halt request from ID (syscall/halt decode).
REQ-008 SHALL have port rom_addr, output, 10, word address to the instruction ROM, equal to pc[11:2].
REQ-009 SHALL have port rom_data_out, input, 32, instruction word from the ROM; combinational in rom_addr, valid in the same cycle.
REQ-010 SHALL have port ifid_pc, output, 32, PC of the instruction held in IF/ID.
REQ-011 SHALL have port ifid_pc4, output, 32, ifid_pc + 4.
REQ-012 SHALL have port ifid_instr, output, 32, instruction held in IF/ID; 32'h0000_0000 (nop) when not valid.
REQ-013 SHALL have port ifid_valid, output, 1, IF/ID holds a real instruction.
REQ-014 SHALL have port halted, output, 1, the FSM is in HALT.

Function
REQ-015 SHALL implement an FSM with three states: BOOT, RUN and HALT.
REQ-016 BOOT: pc=RESET_PC and ifid_valid=0; the FSM SHALL leave BOOT for RUN on the first clock edge after rst_n deasserts, and the first fetch occurs in RUN.
REQ-017 In RUN, each edge SHALL be resolved in this priority order: redirect_valid, then halt, then stall, then normal.
REQ-018 Normal (RUN, none of the above asserted):
- ifid_pc <= pc
- ifid_instr <= rom_data_out
- ifid_valid <= 1
- pc <= pc+4
REQ-019 Redirect (RUN, redirect_valid=1):
- pc <= {redirect_pc[31:2],2'b00}
- ifid_valid <= 0 and ifid_instr <= 0, squashing the wrong-path fetch
- this applies even when stall=1 in the same cycle
REQ-020 Halt (RUN, halt=1, redirect_valid=0):
- the FSM goes to HALT
- ifid_valid <= 0 and ifid_instr <= 0
- pc holds its value
REQ-021 Stall (RUN, stall=1, redirect_valid=0, halt=0): pc, ifid_pc, ifid_instr and ifid_valid SHALL hold.
REQ-022 HALT SHALL be exited only by reset; in HALT, pc holds, ifid_valid=0, and stall/redirect_valid/halt are ignored.
REQ-023 Fetch-to-IF/ID latency SHALL be 1 cycle, and redirect-to-target-in-IF/ID latency SHALL be 2 cycles (one bubble).
REQ-024 pc SHALL be 32 bits and increment modulo 2^32, so 32'hFFFF_FFFC+4 = 0; rom_addr wraps from 10'h3FF to 10'h000 when pc crosses a 4 KiB boundary.
REQ-025 ifid_pc4 SHALL be computed combinationally from ifid_pc with modulo-2^32 wrap.
REQ-026 halted SHALL be 1 exactly while the FSM is in HALT.

Reset
REQ-027 While rst_n=0, the block SHALL hold (asynchronously, independent of clk):
- FSM=BOOT, pc=RESET_PC
- ifid_pc=0, ifid_instr=0, ifid_valid=0
- halted=0
- any counters=0
REQ-028 A reset asserted mid-operation (stall, redirect or HALT) SHALL abort it immediately, and no pending redirect survives reset.

Configuration
REQ-029 When macro FETCH_STAT_EN is defined, the block SHALL add these output ports and counters:
- fetch_cnt[31:0]: increments on each edge that loads ifid_valid=1
- bubble_cnt[31:0]: increments on each RUN edge that stalls or squashes
- both counters saturate at 32'hFFFF_FFFF
- both counters clear only on reset
REQ-030 When FETCH_STAT_EN is undefined, the block SHALL have neither those ports nor that logic, and behaviour SHALL otherwise be identical.

Verification
REQ-031 Reset release, ROM[0..2] = 0x20080001/0x20090002/0x01095020 -> 1st edge: BOOT->RUN, ifid_valid=0; next 3 edges: ifid_pc=0,4,8 with matching ifid_instr; rom_addr = 0,1,2,3.
REQ-032 Stall for 3 cycles at pc=0x10 -> rom_addr stays 4 and IF/ID is unchanged for 3 cycles; on release, ifid_pc=0x10 on the next edge.
REQ-033 redirect_valid=1, redirect_pc=0x0000_0043 with stall=1 at pc=0x20 -> pc=0x40, ifid_valid=0 and ifid_instr=0 for 1 cycle; next edge ifid_pc=0x40; (FETCH_STAT_EN) bubble_cnt +1.
REQ-034 halt=1 at pc=0x30 -> halted=1, ifid_valid=0, pc stays 0x30 for 10 cycles despite redirect_valid=1; rst_n pulse -> pc=RESET_PC, halted=0.
REQ-035 RESET_PC=32'hFFFF_FFF8, free run -> ifid_pc = 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000; rom_addr = 0x3FE, 0x3FF, 0x000.
REQ-036 rst_n asserted between clock edges during a redirect -> outputs reach reset values without a clock edge; first fetch after release is at RESET_PC.

Source files
------------

// File: rtl/fetch_stage.sv
// fetch_stage: PC register, IF/ID pipeline register and BOOT/RUN/HALT control for the instruction fetch stage.
// Optional FETCH_STAT_EN macro adds saturating fetch_cnt/bubble_cnt statistics ports.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  output logic [9:0]  rom_addr,
  input  logic [31:0] rom_data_out,
  output logic [31:0] ifid_pc,
  output logic [31:0] ifid_pc4,
  output logic [31:0] ifid_instr,
  output logic        ifid_valid,
  output logic        halted
`ifdef FETCH_STAT_EN
  ,
  output logic [31:0] fetch_cnt,
  output logic [31:0] bubble_cnt
`endif
);
  typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;
  state_t state, state_n;
  logic [31:0] pc, pc_n, ifid_pc_n, ifid_instr_n;
  logic ifid_valid_n;
  assign rom_addr = pc[11:2];
  assign ifid_pc4 = ifid_pc + 32'd4;
  assign halted = state == HALT;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= BOOT;
      pc <= RESET_PC;
      ifid_pc <= '0;
      ifid_instr <= '0;
      ifid_valid <= 1'b0;
    end else begin
      state <= state_n;
      pc <= pc_n;
      ifid_pc <= ifid_pc_n;
      ifid_instr <= ifid_instr_n;
      ifid_valid <= ifid_valid_n;
    end
  end
  // Priority in RUN: redirect, halt, stall, then a normal fetch.
  always_comb begin
    state_n = state;
    pc_n = pc;
    ifid_pc_n = ifid_pc;
    ifid_instr_n = ifid_instr;
    ifid_valid_n = ifid_valid;
    if (state == BOOT) begin
      state_n = RUN;
    end else if (state == RUN) begin
      if (redirect_valid) begin
        pc_n = redirect_pc & 32'hFFFF_FFFC;
        ifid_instr_n = '0;
        ifid_valid_n = 1'b0;
      end else if (halt) begin
        state_n = HALT;
        ifid_instr_n = '0;
        ifid_valid_n = 1'b0;
      end else if (!stall) begin
        pc_n = pc + 32'd4;
        ifid_pc_n = pc;
        ifid_instr_n = rom_data_out;
        ifid_valid_n = 1'b1;
      end
    end
  end
`ifdef FETCH_STAT_EN
  logic fetch, bubble;
  assign fetch = state == RUN && !redirect_valid && !halt && !stall;
  assign bubble = state == RUN && (redirect_valid || (!halt && stall));
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt <= '0;
      bubble_cnt <= '0;
    end else begin
      if (fetch && !(&fetch_cnt)) fetch_cnt <= fetch_cnt + 32'd1;
      if (bubble && !(&bubble_cnt)) bubble_cnt <= bubble_cnt + 32'd1;
    end
  end
`endif
endmodule
